// File: rtl/fp_mult_responder_if.sv
// Handshake bundle between an evaluator FSM (master) and the multiplier (slave).
interface fp_mult_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mult_start;
  logic [DATA_WIDTH-1:0] mult_operand_a;
  logic [DATA_WIDTH-1:0] mult_operand_b;
  logic [DATA_WIDTH-1:0] mult_result;
  logic                  mult_result_ready;
  logic                  mult_busy;

  modport master (
    output mult_start,
    output mult_operand_a,
    output mult_operand_b,
    input  mult_result,
    input  mult_result_ready,
    input  mult_busy
  );

  modport slave (
    input  mult_start,
    input  mult_operand_a,
    input  mult_operand_b,
    output mult_result,
    output mult_result_ready,
    output mult_busy
  );
endinterface

// File: rtl/fp_mult_responder.sv
// Sequential IEEE-754 multiplier: unpack, 24x24 product, normalise/round.
// Fixed 4-cycle start-to-ready latency, one operation in flight.
module fp_mult_responder #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int DATA_WIDTH   = 32
) (
  input logic               clock,
  input logic               reset,
  fp_mult_responder_if.slave bus
);

  localparam int SIG_LEN  = MANTISSA_LEN + 1;
  localparam int PROD_LEN = 2 * SIG_LEN;
  localparam int EW       = EXP_LEN + 2;

  localparam logic signed [EW-1:0] BIAS    = {3'b000, {(EXP_LEN-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_LEN{1'b1}}};
  localparam logic signed [EW-1:0] ONE     = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] QNAN   =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, PRODUCT, NORM, DONE} state_t;

  state_t state, next_state;
  logic   accept, busy, ready;

  // Latched operands
  logic [DATA_WIDTH-1:0] op_a, op_b;

  // Field split of latched operands
  logic                    sign_a, sign_b;
  logic [EXP_LEN-1:0]      exp_a, exp_b;
  logic [MANTISSA_LEN-1:0] frac_a, frac_b;
  logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  // Unpack stage registers
  logic                  sign_q;
  logic                  special_q;
  logic [DATA_WIDTH-1:0] special_val_q;
  logic [SIG_LEN-1:0]    sig_a_q, sig_b_q;
  logic [EXP_LEN-1:0]    exp_a_q, exp_b_q;

  // Product stage registers
  logic [PROD_LEN-1:0]   prod_q;
  logic signed [EW-1:0]  e_sum_q;

  // Normalise/round combinational results
  logic                    norm_shift;
  logic [MANTISSA_LEN-1:0] mant;
  logic                    guard, sticky, round_up;
  logic [MANTISSA_LEN:0]   mant_rnd;
  logic signed [EW-1:0]    e_norm, e_fin;
  logic [DATA_WIDTH-1:0]   result_d, result_q;

  // Unpack-stage special-case classification
  logic                  special_d;
  logic [DATA_WIDTH-1:0] special_val_d;

  assign sign_a = op_a[DATA_WIDTH-1];
  assign sign_b = op_b[DATA_WIDTH-1];
  assign exp_a  = op_a[DATA_WIDTH-2 -: EXP_LEN];
  assign exp_b  = op_b[DATA_WIDTH-2 -: EXP_LEN];
  assign frac_a = op_a[MANTISSA_LEN-1:0];
  assign frac_b = op_b[MANTISSA_LEN-1:0];

  assign nan_a  = (&exp_a) & (|frac_a);
  assign nan_b  = (&exp_b) & (|frac_b);
  assign inf_a  = (&exp_a) & ~(|frac_a);
  assign inf_b  = (&exp_b) & ~(|frac_b);
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);

  // State register and result register; reset discards any in-flight op
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
    end else begin
      state <= next_state;
      if (state == NORM) result_q <= result_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mult_start) begin
          accept     = 1'b1;
          next_state = UNPACK;
        end
      end
      UNPACK: begin
        busy       = 1'b1;
        next_state = PRODUCT;
      end
      PRODUCT: begin
        busy       = 1'b1;
        next_state = NORM;
      end
      NORM: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (bus.mult_start) begin
          accept     = 1'b1;
          next_state = UNPACK;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Special-case priority: NaN, inf*zero, inf, zero
  always_comb begin
    special_d     = 1'b1;
    special_val_d = '0;
    if (nan_a || nan_b) begin
      special_val_d = QNAN;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      special_val_d = QNAN;
    end else if (inf_a || inf_b) begin
      special_val_d = {sign_a ^ sign_b, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    end else if (zero_a || zero_b) begin
      special_val_d = {sign_a ^ sign_b, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  // Datapath pipeline registers, each stage loaded in its own state
  always_ff @(posedge clock) begin
    if (accept) begin
      op_a <= bus.mult_operand_a;
      op_b <= bus.mult_operand_b;
    end
    if (state == UNPACK) begin
      sign_q        <= sign_a ^ sign_b;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      sig_a_q       <= {1'b1, frac_a};
      sig_b_q       <= {1'b1, frac_b};
      exp_a_q       <= exp_a;
      exp_b_q       <= exp_b;
    end
    if (state == PRODUCT) begin
      prod_q  <= sig_a_q * sig_b_q;
      e_sum_q <= $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q}) - BIAS;
    end
  end

  // Normalise, round to nearest even, then range-check the exponent
  always_comb begin
    norm_shift = prod_q[PROD_LEN-1];
    if (norm_shift) begin
      mant   = prod_q[PROD_LEN-2 -: MANTISSA_LEN];
      guard  = prod_q[PROD_LEN-2-MANTISSA_LEN];
      sticky = |prod_q[PROD_LEN-3-MANTISSA_LEN:0];
      e_norm = e_sum_q + ONE;
    end else begin
      mant   = prod_q[PROD_LEN-3 -: MANTISSA_LEN];
      guard  = prod_q[PROD_LEN-3-MANTISSA_LEN];
      sticky = |prod_q[PROD_LEN-4-MANTISSA_LEN:0];
      e_norm = e_sum_q;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{MANTISSA_LEN{1'b0}}, round_up};
    // A carry out only happens from all-ones, leaving the fraction at zero
    e_fin    = e_norm + {{(EW-1){1'b0}}, mant_rnd[MANTISSA_LEN]};

    if (special_q) begin
      result_d = special_val_q;
    end else if (e_fin >= EXP_MAX) begin
      result_d = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result_d = {sign_q, e_fin[EXP_LEN-1:0], mant_rnd[MANTISSA_LEN-1:0]};
    end
  end

  assign bus.mult_result       = result_q;
  assign bus.mult_result_ready = ready;
  assign bus.mult_busy         = busy;

endmodule

// File: tb/tb_fp_mult_responder.sv
// Self-checking bench for fp_mult_responder with an integer-arithmetic reference model.
module tb_fp_mult_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fp_mult_responder_if #(.DATA_WIDTH(32)) bus ();

  fp_mult_responder #(
    .EXP_LEN(8),
    .MANTISSA_LEN(23),
    .DATA_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference: exact integer product, then RNE by remainder comparison
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [63:0] m, q, rem, half;
    int          h, sh, e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC00000;
    if ((ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
    m = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
    h = 0;
    for (int i = 0; i < 64; i++) if (m[i]) h = i;
    sh   = h - 23;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    e    = int'(ea) + int'(eb) - 127 + (h - 46);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'($urandom_range(1, 20));
      3: v[30:23] = 8'($urandom_range(235, 254));
      4: v[22:0]  = '0;
      5, 6: v[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return v;
  endfunction

  // Issue one operation and wait (bounded) for the ready pulse; lat=0 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(posedge clock); #1;
    bus.mult_start = 1'b1; bus.mult_operand_a = a; bus.mult_operand_b = b;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.mult_result_ready) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    res = bus.mult_result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.mult_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", bus.mult_result, 32'h0); end
    checks++; if (bus.mult_result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.mult_result_ready); end
    checks++; if (bus.mult_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.mult_busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_ready, exp_busy;
    @(posedge clock); #1;
    bus.mult_start = 1'b1; bus.mult_operand_a = 32'h40000000; bus.mult_operand_b = 32'h40400000;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_ready = (k == 4);
      exp_busy  = (k < 4);
      checks++; if (bus.mult_result_ready !== exp_ready) begin errors++; $display("FAIL basic_ready_c%0d: got %b expected %b", k, bus.mult_result_ready, exp_ready); end
      checks++; if (bus.mult_busy !== exp_busy) begin errors++; $display("FAIL basic_busy_c%0d: got %b expected %b", k, bus.mult_busy, exp_busy); end
      if (k >= 4) begin
        checks++; if (bus.mult_result !== 32'h40C00000) begin errors++; $display("FAIL basic_result_c%0d: got %h expected %h", k, bus.mult_result, 32'h40C00000); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [11];
    logic [31:0] vb [11];
    logic [31:0] ve [11];
    logic [31:0] res;
    int lat;
    va = '{32'hBFC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F800000, 32'hFF800000, 32'h7FC12345,
           32'h80000000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h80800000};
    vb = '{32'h40200000, 32'h3F800001, 32'h3FFFFFFF, 32'h00000000, 32'h40000000, 32'h3F800000,
           32'h40000000, 32'h3F800000, 32'h7F000000, 32'h00800000, 32'h00800000};
    ve = '{32'hC0700000, 32'h3F800002, 32'h407FFFFE, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
           32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h80000000};
    for (int i = 0; i < 11; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL directed_latency_%0d: got %0d expected 4", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL directed_%0d %h*%h: got %h expected %h", i, va[i], vb[i], res, ve[i]); end
    end
  endtask

  task automatic test_ignored_start();
    int pulses;
    logic [31:0] res;
    pulses = 0;
    res = '0;
    @(posedge clock); #1;
    bus.mult_start = 1'b1; bus.mult_operand_a = 32'h40000000; bus.mult_operand_b = 32'h40400000;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    @(posedge clock); #1;
    bus.mult_start = 1'b1; bus.mult_operand_a = 32'h40A00000; bus.mult_operand_b = 32'h40A00000;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.mult_result_ready) begin
        pulses++;
        res = bus.mult_result;
      end
      @(posedge clock); #1;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignored_pulses: got %0d expected 1", pulses); end
    checks++; if (res !== 32'h40C00000) begin errors++; $display("FAIL ignored_result: got %h expected %h", res, 32'h40C00000); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run_op(32'h40000000, 32'h40400000, res, lat);
    checks++; if (res !== 32'h40C00000 || lat !== 4) begin errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 4", res, lat, 32'h40C00000); end
    bus.mult_start = 1'b1; bus.mult_operand_a = 32'h40800000; bus.mult_operand_b = 32'h40800000;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    checks++; if (bus.mult_busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap_busy: got %b expected 1", bus.mult_busy); end
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.mult_result_ready) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (bus.mult_result !== 32'h41800000) begin errors++; $display("FAIL b2b_result: got %h expected %h", bus.mult_result, 32'h41800000); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    logic [31:0] res;
    int lat;
    pulses = 0;
    @(posedge clock); #1;
    bus.mult_start = 1'b1; bus.mult_operand_a = 32'h40000000; bus.mult_operand_b = 32'h40400000;
    @(posedge clock); #1;
    bus.mult_start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bus.mult_result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected %h", bus.mult_result, 32'h0); end
    checks++; if (bus.mult_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.mult_busy); end
    for (int k = 0; k < 8; k++) begin
      if (bus.mult_result_ready) pulses++;
      @(posedge clock); #1;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d expected 0", pulses); end
    run_op(32'h40000000, 32'h40400000, res, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midreset_after_latency: got %0d expected 4", lat); end
    checks++; if (res !== 32'h40C00000) begin errors++; $display("FAIL midreset_after_result: got %h expected %h", res, 32'h40C00000); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, want;
    int lat;
    for (int i = 0; i < 80; i++) begin
      a = rand_operand();
      b = rand_operand();
      want = ref_mul(a, b);
      run_op(a, b, res, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL random_latency_%0d: got %0d expected 4", i, lat); end
      checks++; if (res !== want) begin errors++; $display("FAIL random_%0d %h*%h: got %h expected %h", i, a, b, res, want); end
    end
  endtask

  initial begin
    bus.mult_start     = 1'b0;
    bus.mult_operand_a = '0;
    bus.mult_operand_b = '0;
    test_reset();
    test_basic();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
